mem_lsu: RTL and testbench

Load/store initiator that sits between the ktc32 core's execute stage and the byte-addressed program/data RAM. It accepts one core request at a time over a valid/ready handshake and drives the RAM's `we`/`addr`/`wd` pins. It performs byte and halfword loads with sign or zero extension. Sub-word stores use read-modify-write, because the RAM only writes all four bytes `addr..addr+3`. Misaligned and out-of-range accesses are reported as errors and never reach the RAM.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_format.sv | 38 +++
 rtl/mem_lsu.sv | 144 ++++++++++++++
 tb/tb_mem_lsu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the mem_lsu load/store unit.
//   size_e     : access width encoding as carried on req_size
//   state_e    : sequencing states of the unit
//   size_bytes : number of bytes touched by an access of a given size
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_e;

  // Reserved size is reported as 4 bytes; it is rejected by the error check anyway.
  function automatic logic [2:0] size_bytes(input size_e s);
    case (s)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_format.sv
// Combinational data formatting for mem_lsu.
//   size     : access size
//   sgn      : sign-extend loads when 1
//   wdata    : store data (low bytes significant for sub-word stores)
//   mem_data : word read from RAM at the access address
//   rdata    : load result, sign/zero extended
//   merged   : RAM word with the store bytes patched in (read-modify-write)
module lsu_format
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_data,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  always_comb begin
    rdata  = mem_data;
    merged = wdata;
    case (size)
      SIZE_B: begin
        rdata  = {{24{sgn & mem_data[7]}}, mem_data[7:0]};
        merged = {mem_data[31:8], wdata[7:0]};
      end
      SIZE_H: begin
        rdata  = {{16{sgn & mem_data[15]}}, mem_data[15:0]};
        merged = {mem_data[31:16], wdata[15:0]};
      end
      default: begin
        rdata  = mem_data;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator between the core execute stage and the byte-addressed RAM.
// One request at a time; sub-word stores are done as read-modify-write because
// the RAM always writes four bytes. Misaligned, reserved-size and out-of-range
// accesses return resp_err without touching the RAM.
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : request handshake
//   req_we/size/signed/addr/wdata  : request fields
//   resp_valid/resp_ready          : response handshake
//   resp_rdata/resp_err            : response payload
//   mem_we/mem_addr/mem_wd         : RAM write port and address
//   mem_data                       : RAM combinational read of addr..addr+3
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_data
);

  state_e      state_q, state_d;
  // Set for the cycle after acceptance: the unit is still in IDLE but no longer
  // ready, and decides its path from the registered request.
  logic        pend_q;
  logic        we_q, sgn_q, err_q;
  size_e       size_q;
  logic [31:0] addr_q, wdata_q, wd_q, rdata_q;
  logic [31:0] mem_addr_q, mem_wd_q;
  logic        err;
  logic [32:0] end_addr;
  logic [31:0] fmt_rdata, fmt_merged;

  lsu_format u_format (
    .size     (size_q),
    .sgn      (sgn_q),
    .wdata    (wdata_q),
    .mem_data (mem_data),
    .rdata    (fmt_rdata),
    .merged   (fmt_merged)
  );

  // 33-bit end address so an access near 2^32 cannot wrap into range.
  always_comb begin
    end_addr = {1'b0, addr_q} + {30'b0, size_bytes(size_q)};
    err = (size_q == SIZE_RSV)
       || (size_q == SIZE_H && addr_q[0])
       || (size_q == SIZE_W && addr_q[1:0] != 2'b00)
       || (end_addr > 33'(MEM_BYTES));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          if (err)                  state_d = RESP;
          else if (!we_q)           state_d = LOAD;
          else if (size_q == SIZE_W) state_d = WRITE;
          else                      state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = !rst && state_q == IDLE && !pend_q;
    resp_valid = !rst && state_q == RESP;
    mem_we     = !rst && state_q == WRITE;
    mem_addr   = mem_addr_q;
    mem_wd     = mem_wd_q;
    if (state_q == LOAD || state_q == RMW_RD || state_q == WRITE) mem_addr = addr_q;
    if (state_q == WRITE) mem_wd = wd_q;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      size_q     <= SIZE_B;
      addr_q     <= '0;
      wdata_q    <= '0;
      wd_q       <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
    end else begin
      mem_addr_q <= mem_addr;
      mem_wd_q   <= mem_wd;
      case (state_q)
        IDLE: begin
          if (!pend_q) begin
            if (req_valid) begin
              pend_q  <= 1'b1;
              we_q    <= req_we;
              sgn_q   <= req_signed;
              size_q  <= size_e'(req_size);
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              rdata_q <= '0;
              err_q   <= 1'b0;
            end
          end else begin
            pend_q <= 1'b0;
            err_q  <= err;
            wd_q   <= wdata_q;
          end
        end
        LOAD:    rdata_q <= fmt_rdata;
        RMW_RD:  wd_q    <= fmt_merged;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
  localparam int unsigned MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_data;

  int unsigned checks = 0, passes = 0;
  int unsigned we_total = 0;

  bit [7:0] ram     [0:MEM_BYTES-1];
  bit [7:0] ref_mem [0:MEM_BYTES-1];

  always #5 clk = ~clk;

  mem_lsu #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_data(mem_data)
  );

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      if ({32'b0, a} + 64'(i) < 64'(MEM_BYTES)) w[8*i +: 8] = ram[a + 32'(i)];
    return w;
  endfunction

  assign mem_data = ram_word(mem_addr);

  always @(posedge clk) begin
    if (mem_we) begin
      we_total <= we_total + 1;
      for (int i = 0; i < 4; i++)
        if ({32'b0, mem_addr} + 64'(i) < 64'(MEM_BYTES))
          ram[mem_addr + 32'(i)] <= mem_wd[8*i +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One transaction checked against the byte-array reference model.
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int hold, input bit poke);
    int          n, lat, exp_lat;
    logic        err;
    logic [31:0] exp_rd, prev_addr;
    longint      v;
    int unsigned we0;

    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
       || ({32'b0, a} + 64'(n) > 64'(MEM_BYTES));
    exp_rd = '0;
    if (!err && !we) begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(ref_mem[a + 32'(i)]) << (8 * i);
      if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      exp_rd = 32'(v);
    end
    exp_lat = err ? 1 : (we && n < 4) ? 3 : 2;

    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    prev_addr = mem_addr;
    we0 = we_total;
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 99;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin lat = k; break; end
    end
    check("resp_latency", 32'(lat), 32'(exp_lat));

    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0;
      end
      @(posedge clk);
      #1;
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, exp_rd);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end

    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", {31'b0, resp_err}, {31'b0, err});
    check("mem_addr", mem_addr, err ? prev_addr : a);
    check("mem_we_count", 32'(we_total - we0), (we && !err) ? 32'd1 : 32'd0);

    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    req_valid = 1'b0;
    check("idle_ready", {31'b0, req_ready}, 32'd1);
    check("resp_done", {31'b0, resp_valid}, 32'd0);

    if (we && !err)
      for (int i = 0; i < n; i++)
        if ({32'b0, a} + 64'(i) < 64'(MEM_BYTES)) ref_mem[a + 32'(i)] = wd[8*i +: 8];
  endtask

  initial begin
    int diffs;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1 check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_req_ready_rel", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);

    // Word store / load and byte read-modify-write
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    check("ram_word_10", {ram[16'h13], ram[16'h12], ram[16'h11], ram[16'h10]}, 32'hDEADBEEF);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    xact(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055, 0, 1'b0);
    check("ram_word_11", {ram[16'h14], ram[16'h13], ram[16'h12], ram[16'h11]}, 32'h00DEAD55);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0);

    // Sign / zero extension
    xact(1'b1, 2'd0, 1'b0, 32'h20, 32'h12345680, 0, 1'b0);
    xact(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 0, 1'b0);
    xact(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 0, 1'b0);
    xact(1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD8001, 0, 1'b0);
    xact(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0, 1'b0);

    // Errors, including an address that would wrap in 32 bits
    xact(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 0, 1'b0);
    xact(1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, 0, 1'b0);
    xact(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 0, 1'b0);
    xact(1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0, 0, 1'b0);
    xact(1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h12345678, 0, 1'b0);
    xact(1'b1, 2'd0, 1'b0, 32'h3FF, 32'h000000A5, 0, 1'b0);
    xact(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 0, 1'b0);

    // Response backpressure with a competing request presented
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, 1'b1);

    // Reset asserted in the WRITE cycle of a word store
    xact(1'b1, 2'd2, 1'b0, 32'h30, 32'h11111111, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h30; req_wdata = 32'h22222222;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("rstw_in_write", {31'b0, mem_we}, 32'd1);
    rst = 1'b1;
    #1 check("rstw_we_gated", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rstw_ram", ram_word(32'h30), 32'h11111111);
    check("rstw_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) begin
      @(posedge clk);
      #1 check("rstw_no_resp", {31'b0, resp_valid}, 32'd0);
    end

    // Randomized traffic around low memory, the top boundary and huge addresses
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, 63));
        2:       a = 32'($urandom_range(MEM_BYTES - 12, MEM_BYTES - 1));
        default: a = $urandom;
      endcase
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    diffs = 0;
    for (int i = 0; i < int'(MEM_BYTES); i++) if (ram[i] != ref_mem[i]) diffs++;
    check("ram_image_diffs", 32'(diffs), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
